// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and flag bit positions
// used by the condition unit and its evaluator.
package cpu_pkg;

    // Bit positions of the architectural flags inside the 4-bit {N,Z,C,V} word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Instruction condition field encodings (instr[31:28])
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: decides whether an instruction
// with the given condition field executes under the current flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cpass_o
);

    logic n;
    logic z;
    logic c;
    logic v;
    logic ge;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign ge = (n == v);

    // Map each condition encoding onto its flag predicate; NV never passes
    always_comb begin
        cpass_o = 1'b0;
        case (cond_i)
            COND_EQ: cpass_o = z;
            COND_NE: cpass_o = ~z;
            COND_CS: cpass_o = c;
            COND_CC: cpass_o = ~c;
            COND_MI: cpass_o = n;
            COND_PL: cpass_o = ~n;
            COND_VS: cpass_o = v;
            COND_VC: cpass_o = ~v;
            COND_HI: cpass_o = c & ~z;
            COND_LS: cpass_o = ~c | z;
            COND_GE: cpass_o = ge;
            COND_LT: cpass_o = ~ge;
            COND_GT: cpass_o = ~z & ge;
            COND_LE: cpass_o = z | ~ge;
            COND_AL: cpass_o = 1'b1;
            default: cpass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flopenr.sv
// Generic register with synchronous active-high reset and load enable.
module flopenr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Reset clears the register; otherwise it loads only when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/cond_unit.sv
// Condition unit: evaluates the instruction condition against the
// architectural flags, gates the decoder's write requests, and owns the
// flag registers. In multicycle mode the pass bit is captured at decode so
// later flag updates cannot change the fate of the instruction in flight.
module cond_unit
    import cpu_pkg::*;
#(
    parameter int MULTICYCLE = 0,
    parameter int FLAGW_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [FLAGW_W-1:0] FlagW,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               NoWrite,
    input  logic               CondLatch,
    input  logic               NextPC,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               CondEx,
    output logic [3:0]         Flags
);

    localparam logic IS_MULTI = (MULTICYCLE != 0);

    logic cpass;
    logic condExR_q;
    logic condExR_d;
    logic latchEn;
    logic nextPcEn;

    // Pass bit always comes from the flags as they stand this cycle, so a
    // flag write never influences its own enable or a same-cycle latch.
    cond_check u_cond_check (
        .cond_i  (Cond),
        .flags_i (Flags),
        .cpass_o (cpass)
    );

    // Flag storage: either one NZCV group or separate NZ and CV groups
    generate
        if (FLAGW_W == 1) begin : g_flags_one
            flopenr #(.WIDTH(4)) u_flags_nzcv (
                .clk   (clk),
                .reset (reset),
                .en_i  (FlagW[0] & cpass),
                .d_i   (ALUFlags),
                .q_o   (Flags)
            );
        end else begin : g_flags_two
            flopenr #(.WIDTH(2)) u_flags_nz (
                .clk   (clk),
                .reset (reset),
                .en_i  (FlagW[1] & cpass),
                .d_i   (ALUFlags[3:2]),
                .q_o   (Flags[3:2])
            );
            flopenr #(.WIDTH(2)) u_flags_cv (
                .clk   (clk),
                .reset (reset),
                .en_i  (FlagW[0] & cpass),
                .d_i   (ALUFlags[1:0]),
                .q_o   (Flags[1:0])
            );
        end
    endgenerate

    // The multicycle-only strobes are masked off in single-cycle builds
    assign latchEn  = IS_MULTI & CondLatch;
    assign nextPcEn = IS_MULTI & NextPC;

    // Captured pass bit reloads on the decode strobe and holds otherwise
    always_comb begin
        condExR_d = condExR_q;
        if (latchEn) begin
            condExR_d = cpass;
        end
    end

    // Captured pass bit register, cleared by reset ahead of any latch
    always_ff @(posedge clk) begin
        if (reset) begin
            condExR_q <= 1'b0;
        end else begin
            condExR_q <= condExR_d;
        end
    end

    assign CondEx = IS_MULTI ? condExR_q : cpass;

    // Gated controls are forced low while reset is held
    assign PCSrc    = ~reset & PCS & CondEx;
    assign MemWrite = ~reset & MemW & CondEx;
    assign RegWrite = ~reset & RegW & ~NoWrite & CondEx;
    assign PCWrite  = ~reset & (nextPcEn | (PCS & CondEx));

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: a single-cycle / two-group instance and a
// multicycle / one-group instance share the same random and directed stimulus.
module tb_cond_unit;

    typedef struct packed {
        logic       rst;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagW;
        logic       pcs;
        logic       regW;
        logic       memW;
        logic       noWrite;
        logic       latch;
        logic       nextPC;
    } stim_t;

    typedef struct packed {
        logic [3:0] flags;
        logic       condEx;
        logic       pcSrc;
        logic       regWrite;
        logic       memWrite;
        logic       pcWrite;
    } exp_t;

    typedef struct packed {
        exp_t d0;
        exp_t d1;
    } expPair_t;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] aluFlags;
    logic [1:0] flagW;
    logic       pcs;
    logic       regW;
    logic       memW;
    logic       noWrite;
    logic       condLatch;
    logic       nextPC;

    logic       pcSrc0, regWrite0, memWrite0, pcWrite0, condEx0;
    logic [3:0] flags0;
    logic       pcSrc1, regWrite1, memWrite1, pcWrite1, condEx1;
    logic [3:0] flags1;
    logic [0:0] flagW1;

    int checkCount = 0;
    int errorCount = 0;
    bit finished   = 0;

    expPair_t expQ[$];

    logic [3:0] mFlags0;
    logic [3:0] mFlags1;
    logic       mCondExR;

    assign flagW1 = flagW[0:0];

    cond_unit #(.MULTICYCLE(0), .FLAGW_W(2)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .Cond      (cond),
        .ALUFlags  (aluFlags),
        .FlagW     (flagW),
        .PCS       (pcs),
        .RegW      (regW),
        .MemW      (memW),
        .NoWrite   (noWrite),
        .CondLatch (condLatch),
        .NextPC    (nextPC),
        .PCSrc     (pcSrc0),
        .RegWrite  (regWrite0),
        .MemWrite  (memWrite0),
        .PCWrite   (pcWrite0),
        .CondEx    (condEx0),
        .Flags     (flags0)
    );

    cond_unit #(.MULTICYCLE(1), .FLAGW_W(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .Cond      (cond),
        .ALUFlags  (aluFlags),
        .FlagW     (flagW1),
        .PCS       (pcs),
        .RegW      (regW),
        .MemW      (memW),
        .NoWrite   (noWrite),
        .CondLatch (condLatch),
        .NextPC    (nextPC),
        .PCSrc     (pcSrc1),
        .RegWrite  (regWrite1),
        .MemWrite  (memWrite1),
        .PCWrite   (pcWrite1),
        .CondEx    (condEx1),
        .Flags     (flags1)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference condition rule: pairs of encodings share a predicate and the
    // odd member of each pair is its complement; 1111 never passes
    function automatic logic refPass(input logic [3:0] c, input logic [3:0] f);
        logic       n, z, cc, v;
        logic [7:0] pred;
        logic [2:0] idx;
        n    = f[3];
        z    = f[2];
        cc   = f[1];
        v    = f[0];
        pred = {1'b1, ~z & (n == v), (n == v), cc & ~z, v, n, cc, z};
        idx  = c[3:1];
        if (c == 4'b1111) return 1'b0;
        return pred[idx] ^ c[0];
    endfunction

    function automatic stim_t mk(input logic r, input logic [3:0] c, input logic [3:0] a,
                                 input logic [1:0] fw, input logic p, input logic rw,
                                 input logic mw, input logic nw, input logic lt, input logic np);
        stim_t s;
        s.rst = r; s.cond = c; s.alu = a; s.flagW = fw; s.pcs = p;
        s.regW = rw; s.memW = mw; s.noWrite = nw; s.latch = lt; s.nextPC = np;
        return s;
    endfunction

    // Drive one cycle, queue the expected response, then advance the model
    task automatic applyStimulus(input stim_t s);
        expPair_t e;
        logic     p0, p1;
        reset     = s.rst;
        cond      = s.cond;
        aluFlags  = s.alu;
        flagW     = s.flagW;
        pcs       = s.pcs;
        regW      = s.regW;
        memW      = s.memW;
        noWrite   = s.noWrite;
        condLatch = s.latch;
        nextPC    = s.nextPC;

        p0 = refPass(s.cond, mFlags0);
        p1 = refPass(s.cond, mFlags1);

        e.d0.flags    = mFlags0;
        e.d0.condEx   = p0;
        e.d0.pcSrc    = !s.rst && s.pcs && p0;
        e.d0.regWrite = !s.rst && s.regW && !s.noWrite && p0;
        e.d0.memWrite = !s.rst && s.memW && p0;
        e.d0.pcWrite  = e.d0.pcSrc;

        e.d1.flags    = mFlags1;
        e.d1.condEx   = mCondExR;
        e.d1.pcSrc    = !s.rst && s.pcs && mCondExR;
        e.d1.regWrite = !s.rst && s.regW && !s.noWrite && mCondExR;
        e.d1.memWrite = !s.rst && s.memW && mCondExR;
        e.d1.pcWrite  = !s.rst && (s.nextPC || (s.pcs && mCondExR));

        expQ.push_back(e);
        @(posedge clk);

        if (s.rst) begin
            mFlags0  = 4'b0000;
            mFlags1  = 4'b0000;
            mCondExR = 1'b0;
        end else begin
            if (s.flagW[1] && p0) mFlags0[3:2] = s.alu[3:2];
            if (s.flagW[0] && p0) mFlags0[1:0] = s.alu[1:0];
            if (s.flagW[0] && p1) mFlags1 = s.alu;
            if (s.latch) mCondExR = p1;
        end
        #1;
    endtask

    task automatic checkOne(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    // Compare every output of both instances against a popped expectation
    task automatic checkOutput(input expPair_t e);
        checkOne("dut0.Flags",    flags0,            e.d0.flags);
        checkOne("dut0.CondEx",   {3'b0, condEx0},   {3'b0, e.d0.condEx});
        checkOne("dut0.PCSrc",    {3'b0, pcSrc0},    {3'b0, e.d0.pcSrc});
        checkOne("dut0.RegWrite", {3'b0, regWrite0}, {3'b0, e.d0.regWrite});
        checkOne("dut0.MemWrite", {3'b0, memWrite0}, {3'b0, e.d0.memWrite});
        checkOne("dut0.PCWrite",  {3'b0, pcWrite0},  {3'b0, e.d0.pcWrite});
        checkOne("dut1.Flags",    flags1,            e.d1.flags);
        checkOne("dut1.CondEx",   {3'b0, condEx1},   {3'b0, e.d1.condEx});
        checkOne("dut1.PCSrc",    {3'b0, pcSrc1},    {3'b0, e.d1.pcSrc});
        checkOne("dut1.RegWrite", {3'b0, regWrite1}, {3'b0, e.d1.regWrite});
        checkOne("dut1.MemWrite", {3'b0, memWrite1}, {3'b0, e.d1.memWrite});
        checkOne("dut1.PCWrite",  {3'b0, pcWrite1},  {3'b0, e.d1.pcWrite});
    endtask

    // Monitor: outputs are valid every cycle, so sample mid-cycle on the falling edge
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        stim_t s;
        reset = 1'b1; cond = 4'b0; aluFlags = 4'b0; flagW = 2'b0;
        pcs = 1'b0; regW = 1'b0; memW = 1'b0; noWrite = 1'b0;
        condLatch = 1'b0; nextPC = 1'b0;
        @(posedge clk);
        #1;
        mFlags0 = 4'b0; mFlags1 = 4'b0; mCondExR = 1'b0;

        // reset held with every request high: gated outputs low
        applyStimulus(mk(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1));
        // after reset EQ fails, NE passes
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0));
        // NZ group then CV group writes
        applyStimulus(mk(0, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0));
        // N=V=1: GE, LT, GT; then set Z and try LE
        applyStimulus(mk(0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b1010, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 4'b1011, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 4'b1100, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 4'b1110, 4'b1101, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b1101, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        // failing EQ must not write flags or registers
        applyStimulus(mk(0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b1111, 2'b11, 0, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 0, 0, 0));
        // multicycle latch holds across a later flag change
        applyStimulus(mk(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0));
        applyStimulus(mk(0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        // latch and flag write together capture the old-flag result
        applyStimulus(mk(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 0));
        applyStimulus(mk(0, 4'b0000, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0));
        // NV with every request high, then reset mid-sequence
        applyStimulus(mk(0, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4'b1111, 4'b0101, 2'b11, 1, 1, 1, 0, 1, 1));
        applyStimulus(mk(0, 4'b1111, 4'b0101, 2'b11, 1, 1, 1, 0, 0, 0));
        applyStimulus(mk(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1));
        applyStimulus(mk(0, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 1, 0, 0));

        for (int i = 0; i < 400; i++) begin
            s.rst     = ($urandom_range(0, 24) == 0);
            s.cond    = 4'($urandom_range(0, 15));
            s.alu     = 4'($urandom_range(0, 15));
            s.flagW   = 2'($urandom_range(0, 3));
            s.pcs     = 1'($urandom_range(0, 1));
            s.regW    = 1'($urandom_range(0, 1));
            s.memW    = 1'($urandom_range(0, 1));
            s.noWrite = 1'($urandom_range(0, 1));
            s.latch   = ($urandom_range(0, 2) == 0);
            s.nextPC  = ($urandom_range(0, 3) == 0);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        checkCount++;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboardDrain: %0d pending, expected 0", expQ.size());
        end
        finished = 1;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Watchdog in case the stimulus process ever stalls
    initial begin
        #200000;
        if (!finished) begin
            errorCount++;
            $display("[TB] FAIL watchdog: time %0t reached, expected completion earlier", $time);
            $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
            $finish;
        end
    end

endmodule
